// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and data access (D).
// One transaction in flight; data has priority, bounded by a streak limit so fetch cannot starve.
`timescale 1ns/1ps
module rv32i_mem_arbiter #(
    parameter int WIDTH           = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    input  logic             i_flush,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [WIDTH-1:0] i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [3:0]       d_be,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [WIDTH-1:0] d_rdata,
    output logic             m_req,
    output logic             m_we,
    output logic [3:0]       m_be,
    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_wdata,
    input  logic             m_ready,
    input  logic             m_rvalid,
    input  logic [WIDTH-1:0] m_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t     state, state_next;
    owner_t     owner;
    logic       drop;
    logic [3:0] streak;

    logic arb_point, fetch_first, fetch_win, data_win, accept, resp;

    // NOTE: every output of this block gets a default before any branch, so no latches are inferred.
    always_comb begin
        arb_point   = (state == IDLE) || ((state == WAIT) && m_rvalid);
        fetch_first = i_req && (!d_req || (streak == STREAK_MAX));
        fetch_win   = arb_point && fetch_first;
        data_win    = arb_point && d_req && !fetch_first;
        accept      = (state == ISSUE) && m_req && m_ready;
        resp        = (state == WAIT) && m_rvalid;

        i_gnt    = accept && (owner == OWN_I);
        d_gnt    = accept && (owner == OWN_D);
        i_rvalid = resp && (owner == OWN_I) && !drop;
        d_rvalid = resp && (owner == OWN_D);
        i_rdata  = m_rdata;
        d_rdata  = m_rdata;

        state_next = state;
        case (state)
            IDLE:    if (fetch_win || data_win) state_next = ISSUE;
            ISSUE:   if (accept) state_next = WAIT;
            WAIT:    if (resp) state_next = (fetch_win || data_win) ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Winner's payload is latched onto the memory port and held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= 4'h0;
            m_addr  <= '0;
            m_wdata <= '0;
            owner   <= OWN_I;
        end else if (fetch_win) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_be    <= 4'hF;
            m_addr  <= i_addr;
            m_wdata <= '0;
            owner   <= OWN_I;
        end else if (data_win) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_be    <= d_be;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            owner   <= OWN_D;
        end else if (accept) begin
            m_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      streak <= 4'd0;
        else if (i_gnt)               streak <= 4'd0;
        else if (d_gnt && i_req)      streak <= (streak == 4'hF) ? streak : streak + 4'd1;
        else if (arb_point && !i_req) streak <= 4'd0;
    end

    // A squashed fetch still occupies the memory; only its response is hidden.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       drop <= 1'b0;
        else if (fetch_win && i_flush) drop <= 1'b1;
        else if (resp)                 drop <= 1'b0;
        else if (i_flush && (owner == OWN_I) && ((state == ISSUE) || (state == WAIT)))
                                       drop <= 1'b1;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Arbitrates a single-port unified memory between the instruction-fetch (IF) and data-access (MEM) stages of the rv32i_core pipeline. Only one transaction is outstanding at a time. Data accesses have priority, and a streak limit prevents fetch starvation. Responses are routed back to the owning requester, and in-flight fetches can be squashed on a pipeline flush.

## Interface
- WIDTH, 32: data and address width in bits.
- MAX_DATA_STREAK, 4: maximum consecutive data grants while a fetch waits (range 1–15).

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  WIDTH  fetch byte address.
- i_flush  in  1  squash any in-flight fetch response (branch/jump redirect).
- i_gnt  out  1  one-cycle pulse: fetch accepted by memory.
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  WIDTH  fetch data.
- d_req, d_we  in  1 each  data request and write enable; held with the payload until d_gnt.
- d_be  in  4  byte enables.
- d_addr, d_wdata  in  WIDTH each  data address and write data.
- d_gnt  out  1  one-cycle pulse: data access accepted.
- d_rvalid  out  1  one-cycle pulse: read data valid or write acknowledged.
- d_rdata  out  WIDTH  load data.
- m_req, m_we  out  1 each  memory request and write enable.
- m_be  out  4  memory byte enables.
- m_addr, m_wdata  out  WIDTH each  memory address and write data.
- m_ready  in  1  memory accepts m_req this cycle.
- m_rvalid  in  1  memory response (read data or write ack), at least 1 cycle after acceptance.
- m_rdata  in  WIDTH  memory read data.

## Operation
- State machine: IDLE, ISSUE, WAIT.
- Registered state: owner (I/D), drop flag, streak counter (4 bits).
- Arbitration runs in IDLE, and in WAIT on the cycle m_rvalid arrives:
  - Only d_req: data wins.
  - Only i_req: fetch wins.
  - Both: data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
- Winning the arbitration:
  - Request payload is registered onto m_* and m_req is set.
  - Owner is recorded; the next state is ISSUE.
  - Fetch payload drives m_we=0, m_be=4'hF, m_wdata=0.
- ISSUE:
  - m_req is held with stable payload until m_ready.
  - On m_req & m_ready: the owner's gnt pulses (combinational), m_req is cleared at the edge, and the next state is WAIT.
- WAIT:
  - On m_rvalid, the owner's rvalid = m_rvalid, unless the owner is I and drop is set; then i_rvalid stays 0.
  - x_rdata = m_rdata, passed through combinationally.
  - Next state is ISSUE if a request is pending, otherwise IDLE.
- Streak counter:
  - Increments (saturating) on each data grant while i_req = 1.
  - Clears on a fetch grant, or when i_req = 0 at an arbitration point.
- Drop flag:
  - Set when i_flush = 1 while owner = I in ISSUE or WAIT.
  - Set when i_flush coincides with a fetch win.
  - Cleared when the owner's response completes.
- i_flush in IDLE with no fetch selected: no effect. Flush never withdraws m_req once asserted.
- i_gnt/d_gnt and i_rvalid/d_rvalid are never high in the same cycle as each other.

## Timing
- Reset: state IDLE; m_req, m_we, m_be, m_addr, m_wdata = 0; i_gnt, d_gnt, i_rvalid, d_rvalid = 0; streak = 0; drop = 0.
- Reset mid-transaction aborts immediately. A late m_rvalid in IDLE is ignored and produces no rvalid.
- Minimum latency with m_ready = 1 and a 1-cycle memory:
  - Request at cycle 0, m_req at cycle 1, gnt at cycle 1.
  - m_rvalid and x_rvalid at cycle 2.
  - Back-to-back: the next m_req is at cycle 3, giving one transaction per 2 cycles.
- m_ready low: stay in ISSUE indefinitely with no gnt. Payload is stable; requesters keep req asserted.
- A requester that drops req before gnt once it has been selected is a protocol violation. The arbiter completes the already latched transaction.

## Test plan
- Fetch only, i_addr = 0x00000010, m_ready = 1, memory returns 0x00500093 one cycle after acceptance:
  - m_req and i_gnt at cycle 1; i_rvalid = 1 with i_rdata = 0x00500093 at cycle 2.
  - d_gnt and d_rvalid stay 0.
- Simultaneous i_req and d_req (store, d_addr = 0x100, d_wdata = 0xDEADBEEF, d_be = 4'hF):
  - Data granted first with m_we = 1.
  - d_rvalid ack, then fetch granted in the following ISSUE.
- Both held continuously with MAX_DATA_STREAK = 4 → grant order D, D, D, D, I, D, D, D, D, I.
- i_flush asserted one cycle after i_gnt (WAIT):
  - m_rvalid arrives but i_rvalid stays 0.
  - The next fetch response is delivered normally.
- m_ready held low 5 cycles in ISSUE:
  - m_req and m_addr stable, no gnt.
  - gnt on the cycle m_ready rises.
- rst pulsed during WAIT:
  - All outputs 0 asynchronously.
  - A subsequent stray m_rvalid produces no i_rvalid/d_rvalid.
